// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: per-stage widths, control-bundle bit layout and NOP bundles.
package pipe_pkg;

  localparam int IF_ID_DATA_W  = 64;
  localparam int IF_ID_CTRL_W  = 1;
  localparam int ID_EX_DATA_W  = 165;
  localparam int ID_EX_CTRL_W  = 13;
  localparam int EX_MEM_DATA_W = 107;
  localparam int EX_MEM_CTRL_W = 5;
  localparam int MEM_WB_DATA_W = 69;
  localparam int MEM_WB_CTRL_W = 2;

  // ID/EX control bundle bit positions
  localparam int CTRL_EX_REG_DST   = 0;
  localparam int CTRL_EX_ALU_SRC   = 1;
  localparam int CTRL_EX_ALU_OP_LO = 2;
  localparam int CTRL_EX_ALU_OP_HI = 3;
  localparam int CTRL_M_BRANCH     = 4;
  localparam int CTRL_M_MEM_READ   = 5;
  localparam int CTRL_M_MEM_WRITE  = 6;
  localparam int CTRL_WB_REG_WRITE = 7;
  localparam int CTRL_WB_MEM_TO_REG = 8;
  localparam int CTRL_EX_JUMP      = 9;
  localparam int CTRL_M_BNE        = 10;
  localparam int CTRL_EX_SHIFT     = 11;
  localparam int CTRL_WB_LINK      = 12;

  localparam logic [ID_EX_CTRL_W-1:0]  ID_EX_NOP  = '0;
  localparam logic [EX_MEM_CTRL_W-1:0] EX_MEM_NOP = '0;
  localparam logic [MEM_WB_CTRL_W-1:0] MEM_WB_NOP = '0;

  function automatic logic id_ex_has_side_effect(input logic [ID_EX_CTRL_W-1:0] ctrl);
    return ctrl[CTRL_WB_REG_WRITE] | ctrl[CTRL_M_MEM_WRITE];
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Second-entry holding register for pipe_stage_hs, plus the registered in_ready it implies.
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int DATA_W = ID_EX_DATA_W,
  parameter int CTRL_W = ID_EX_CTRL_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              accept,
  input  logic              consume,
  input  logic              main_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              skid_valid,
  output logic [DATA_W-1:0] skid_data,
  output logic [CTRL_W-1:0] skid_ctrl,
  output logic              in_ready
);

  logic              skid_valid_reg;
  logic              skid_valid_next;
  logic [DATA_W-1:0] skid_data_reg;
  logic [CTRL_W-1:0] skid_ctrl_reg;
  logic              in_ready_reg;
  logic              load;

  // A new entry lands here only when main is occupied and not draining.
  assign load = accept & main_valid & ~consume & ~flush;

  always_comb begin
    skid_valid_next = skid_valid_reg;
    if (flush)        skid_valid_next = 1'b0;
    else if (load)    skid_valid_next = 1'b1;
    else if (consume) skid_valid_next = 1'b0;
  end

  // Skid occupied implies main occupied, so next occupancy < 2 is just !skid_valid_next.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      skid_valid_reg <= 1'b0;
      skid_data_reg  <= '0;
      skid_ctrl_reg  <= '0;
      in_ready_reg   <= 1'b0;
    end else begin
      skid_valid_reg <= skid_valid_next;
      in_ready_reg   <= ~skid_valid_next;
      if (load) begin
        skid_data_reg <= in_data;
        skid_ctrl_reg <= in_ctrl;
      end
    end
  end

  assign skid_valid = skid_valid_reg;
  assign skid_data  = skid_data_reg;
  assign skid_ctrl  = skid_ctrl_reg;
  assign in_ready   = in_ready_reg;

endmodule

// File: rtl/pipe_stage_hs.sv
// Handshaked MIPS pipeline stage register with optional skid entry, flush-to-bubble
// and a saturating stall counter.
module pipe_stage_hs
  import pipe_pkg::*;
#(
  parameter int                 DATA_W      = ID_EX_DATA_W,
  parameter int                 CTRL_W      = ID_EX_CTRL_W,
  parameter logic [CTRL_W-1:0]  CTRL_BUBBLE = '0,
  parameter bit                 SKID_EN     = 1'b1,
  parameter int                 STALL_W     = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [CTRL_W-1:0]  in_ctrl,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [CTRL_W-1:0]  out_ctrl,
  output logic [1:0]         occupancy,
  output logic [STALL_W-1:0] stall_cnt,
  input  logic               stall_clr
);

  logic               main_valid_reg, main_valid_next;
  logic [DATA_W-1:0]  main_data_reg, main_data_next;
  logic [CTRL_W-1:0]  main_ctrl_reg, main_ctrl_next;
  logic [STALL_W-1:0] stall_cnt_reg, stall_cnt_next;
  logic               skid_valid;
  logic [DATA_W-1:0]  skid_data;
  logic [CTRL_W-1:0]  skid_ctrl;
  logic               accept, consume;

  assign accept  = in_valid & in_ready;
  assign consume = main_valid_reg & out_ready;

  generate
    if (SKID_EN) begin : gen_skid
      pipe_skid_buf #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
      ) u_skid (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .accept     (accept),
        .consume    (consume),
        .main_valid (main_valid_reg),
        .in_data    (in_data),
        .in_ctrl    (in_ctrl),
        .skid_valid (skid_valid),
        .skid_data  (skid_data),
        .skid_ctrl  (skid_ctrl),
        .in_ready   (in_ready)
      );
    end else begin : gen_no_skid
      assign skid_valid = 1'b0;
      assign skid_data  = '0;
      assign skid_ctrl  = '0;
      assign in_ready   = ~reset & (~main_valid_reg | out_ready);
    end
  endgenerate

  // When main frees up, the older skid entry always takes precedence over new input.
  always_comb begin
    main_valid_next = main_valid_reg;
    main_data_next  = main_data_reg;
    main_ctrl_next  = main_ctrl_reg;
    if (flush) begin
      main_valid_next = 1'b0;
    end else if (~main_valid_reg | consume) begin
      if (skid_valid) begin
        main_valid_next = 1'b1;
        main_data_next  = skid_data;
        main_ctrl_next  = skid_ctrl;
      end else if (accept) begin
        main_valid_next = 1'b1;
        main_data_next  = in_data;
        main_ctrl_next  = in_ctrl;
      end else begin
        main_valid_next = 1'b0;
      end
    end
  end

  always_comb begin
    stall_cnt_next = stall_cnt_reg;
    if (stall_clr)
      stall_cnt_next = '0;
    else if (main_valid_reg & ~out_ready & ~flush & (stall_cnt_reg != '1))
      stall_cnt_next = stall_cnt_reg + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_valid_reg <= 1'b0;
      main_data_reg  <= '0;
      main_ctrl_reg  <= CTRL_BUBBLE;
      stall_cnt_reg  <= '0;
    end else begin
      main_valid_reg <= main_valid_next;
      main_data_reg  <= main_data_next;
      main_ctrl_reg  <= main_ctrl_next;
      stall_cnt_reg  <= stall_cnt_next;
    end
  end

  assign out_valid = main_valid_reg;
  assign out_data  = main_data_reg;
  assign out_ctrl  = main_valid_reg ? main_ctrl_reg : CTRL_BUBBLE;
  assign occupancy = {1'b0, main_valid_reg} + {1'b0, skid_valid};
  assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Scoreboard bench for pipe_stage_hs: skid instance under directed + random traffic,
// plus a no-skid, 3-bit stall counter instance for combinational ready and saturation.
module tb_pipe_stage_hs;

  typedef struct packed {
    logic [12:0]  ctrl;
    logic [164:0] data;
  } ent_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0, in_ready;
  logic [164:0] in_data = '0;
  logic [12:0]  in_ctrl = '0;
  logic         flush = 1'b0;
  logic         out_valid, out_ready = 1'b0;
  logic [164:0] out_data;
  logic [12:0]  out_ctrl;
  logic [1:0]   occupancy;
  logic [15:0]  stall_cnt;
  logic         stall_clr = 1'b0;

  logic         reset0 = 1'b1;
  logic         in_valid0 = 1'b0, in_ready0;
  logic [7:0]   in_data0 = '0;
  logic [3:0]   in_ctrl0 = '0;
  logic         out_valid0, out_ready0 = 1'b0;
  logic [7:0]   out_data0;
  logic [3:0]   out_ctrl0;
  logic [1:0]   occupancy0;
  logic [2:0]   stall_cnt0;
  logic         stall_clr0 = 1'b0;
  logic         flush0 = 1'b0;

  int   checks = 0;
  int   errors = 0;
  int   xfers  = 0;
  bit   warm   = 1'b0;
  bit   done0  = 1'b0;
  ent_t exp_q[$];
  int   stall_exp = 0;

  always #5 clk = ~clk;

  pipe_stage_hs dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .occupancy(occupancy), .stall_cnt(stall_cnt), .stall_clr(stall_clr)
  );

  pipe_stage_hs #(.DATA_W(8), .CTRL_W(4), .CTRL_BUBBLE(4'h0), .SKID_EN(1'b0), .STALL_W(3)) dut0 (
    .clk(clk), .reset(reset0), .in_valid(in_valid0), .in_ready(in_ready0),
    .in_data(in_data0), .in_ctrl(in_ctrl0), .flush(flush0), .out_valid(out_valid0),
    .out_ready(out_ready0), .out_data(out_data0), .out_ctrl(out_ctrl0),
    .occupancy(occupancy0), .stall_cnt(stall_cnt0), .stall_clr(stall_clr0)
  );

  task automatic check(input string name, input logic [191:0] got, input logic [191:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [164:0] rnd_data();
    logic [191:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return t[164:0];
  endfunction

  // Inputs change 0 after negedge; driver-side spot checks happen at +1.
  task automatic drive(input logic v, input logic [164:0] d, input logic [12:0] c,
                       input logic r, input logic f, input logic clr);
    in_valid = v; in_data = d; in_ctrl = c; out_ready = r; flush = f; stall_clr = clr;
    #1;
  endtask

  // Stimulus side of the scoreboard: record every accepted entry just before the edge.
  task automatic fin();
    ent_t e;
    #3;
    if (!reset && in_valid && in_ready && !flush) begin
      e.ctrl = in_ctrl;
      e.data = in_data;
      exp_q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic r);
    drive(1'b0, '0, '0, r, 1'b0, 1'b0);
  endtask

  // Monitor: checks state against the reference queue at +2, retires consumed entries at +4.
  initial begin
    int   sz;
    ent_t head;
    forever begin
      @(negedge clk);
      #2;
      sz = exp_q.size();
      if (warm && !reset) begin
        check("occupancy", 192'(occupancy), 192'(sz));
        check("out_valid", 192'(out_valid), 192'(sz > 0));
        check("in_ready", 192'(in_ready), 192'(sz < 2));
        if (sz == 0) check("bubble_ctrl", 192'(out_ctrl), 192'(0));
        check("stall_cnt", 192'(stall_cnt), 192'(stall_exp));
      end
      #2;
      if (reset) begin
        exp_q.delete();
        stall_exp = 0;
        warm = 1'b0;
      end else begin
        if (out_valid && out_ready) begin
          if (sz == 0) begin
            check("spurious_out", 192'(1), 192'(0));
          end else begin
            head = exp_q.pop_front();
            check("out_data", 192'(out_data), 192'(head.data));
            check("out_ctrl", 192'(out_ctrl), 192'(head.ctrl));
            xfers++;
            $display("xfer %0d ctrl=%h data_lo=%h flush=%0b", xfers, out_ctrl, out_data[31:0], flush);
          end
        end
        if (flush) exp_q.delete();
        if (stall_clr) stall_exp = 0;
        else if (sz > 0 && !out_ready && !flush && stall_exp != 16'hffff) stall_exp++;
        warm = 1'b1;
      end
    end
  end

  // Main-instance stimulus.
  initial begin
    bit acc;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    idle(1'b1); fin();
    idle(1'b1); check("rdy_after_reset", 192'(in_ready), 192'(1)); fin();

    // back-to-back throughput
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 165'(i), 13'(i), 1'b1, 1'b0, 1'b0);
      check("b2b_occ", 192'(occupancy), 192'(i == 1 ? 0 : 1));
      fin();
    end
    idle(1'b1); check("b2b_last", 192'(out_data), 192'(8)); fin();
    idle(1'b1); fin();

    // backpressure into the skid, then drain in order
    drive(1'b1, 165'h0A, 13'h0A1, 1'b0, 1'b0, 1'b0); fin();
    drive(1'b1, 165'h0B, 13'h0B2, 1'b0, 1'b0, 1'b0); fin();
    drive(1'b1, 165'h0C, 13'h0C3, 1'b0, 1'b0, 1'b0);
    check("bp_occ2", 192'(occupancy), 192'(2));
    check("bp_rdy0", 192'(in_ready), 192'(0));
    fin();
    acc = 1'b0;
    for (int k = 0; k < 10 && !acc; k++) begin
      drive(1'b1, 165'h0C, 13'h0C3, 1'b1, 1'b0, 1'b0);
      acc = in_ready;
      fin();
    end
    check("bp_c_accepted", 192'(acc), 192'(1));
    repeat (3) begin idle(1'b1); fin(); end

    // flush with a full stage and a valid incoming entry
    drive(1'b1, 165'h1A, 13'h111, 1'b0, 1'b0, 1'b0); fin();
    drive(1'b1, 165'h1B, 13'h122, 1'b0, 1'b0, 1'b0); fin();
    drive(1'b1, 165'h1D, 13'h1DD, 1'b0, 1'b1, 1'b0);
    check("fl_occ_before", 192'(occupancy), 192'(2));
    fin();
    idle(1'b0);
    check("fl_occ", 192'(occupancy), 192'(0));
    check("fl_valid", 192'(out_valid), 192'(0));
    check("fl_ctrl", 192'(out_ctrl), 192'(0));
    check("fl_rdy", 192'(in_ready), 192'(1));
    fin();

    // stall counter: 5 stalled cycles, then clear
    drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b1); fin();
    drive(1'b1, 165'h2E, 13'h0EE, 1'b0, 1'b0, 1'b0); fin();
    repeat (5) begin idle(1'b0); fin(); end
    idle(1'b0); check("stall_5", 192'(stall_cnt), 192'(5)); fin();
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1); fin();
    idle(1'b1); check("stall_clr", 192'(stall_cnt), 192'(0)); fin();
    idle(1'b1); fin();

    // asynchronous reset mid-stream
    drive(1'b1, 165'h3A, 13'h1AA, 1'b0, 1'b0, 1'b0); fin();
    drive(1'b1, 165'h3B, 13'h1BB, 1'b0, 1'b0, 1'b0); fin();
    idle(1'b0);
    check("rs_occ_before", 192'(occupancy), 192'(2));
    reset = 1'b1;
    #1;
    check("rs_valid", 192'(out_valid), 192'(0));
    check("rs_occ", 192'(occupancy), 192'(0));
    check("rs_ctrl", 192'(out_ctrl), 192'(0));
    check("rs_rdy", 192'(in_ready), 192'(0));
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    idle(1'b1); check("rs_rdy_hold", 192'(in_ready), 192'(0)); fin();
    idle(1'b1); check("rs_rdy_release", 192'(in_ready), 192'(1)); fin();

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 3) != 0, rnd_data(), 13'($urandom_range(0, 8191)),
            $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0, $urandom_range(0, 29) == 0);
      fin();
    end
    repeat (4) begin idle(1'b1); fin(); end
    check("drained", 192'(exp_q.size()), 192'(0));

    for (int k = 0; k < 200 && !done0; k++) @(negedge clk);
    check("nsk_done", 192'(done0), 192'(1));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // No-skid instance: combinational in_ready, occupancy <= 1, 3-bit saturation.
  initial begin
    @(negedge clk); @(negedge clk);
    reset0 = 1'b0;
    @(negedge clk);
    in_valid0 = 1'b1; in_data0 = 8'h5a; in_ctrl0 = 4'h3; out_ready0 = 1'b0;
    #1 check("nsk_rdy_empty", 192'(in_ready0), 192'(1));
    @(negedge clk);
    in_data0 = 8'h5b; in_ctrl0 = 4'h6;
    #1;
    check("nsk_valid", 192'(out_valid0), 192'(1));
    check("nsk_data_a", 192'(out_data0), 192'(8'h5a));
    check("nsk_rdy_stall", 192'(in_ready0), 192'(0));
    out_ready0 = 1'b1;
    #1 check("nsk_rdy_go", 192'(in_ready0), 192'(1));
    @(negedge clk);
    in_valid0 = 1'b0; out_ready0 = 1'b0; stall_clr0 = 1'b1;
    #1;
    check("nsk_data_b", 192'(out_data0), 192'(8'h5b));
    check("nsk_ctrl_b", 192'(out_ctrl0), 192'(4'h6));
    @(negedge clk);
    stall_clr0 = 1'b0;
    #1 check("nsk_stall0", 192'(stall_cnt0), 192'(0));
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      #1;
      check("nsk_occ", 192'(occupancy0), 192'(1));
      check("nsk_stall_sat", 192'(stall_cnt0), 192'(i < 7 ? i : 7));
    end
    stall_clr0 = 1'b1;
    @(negedge clk);
    stall_clr0 = 1'b0; out_ready0 = 1'b1;
    #1 check("nsk_clr", 192'(stall_cnt0), 192'(0));
    @(negedge clk);
    #1;
    check("nsk_empty", 192'(out_valid0), 192'(0));
    check("nsk_bubble", 192'(out_ctrl0), 192'(0));
    done0 = 1'b1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
